// File: rtl/decode_issue_stage.sv
// MIPS D stage: IF/ID register, instruction decode, Tnew scoreboard and MDU busy tracking.
// Define FWD_PATHS_EN to stall only when a producer's Tnew exceeds the consumer's Tuse.
module decode_issue_stage #(
  parameter int NSTAGE  = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [4:0]  out_a3,
  output logic        out_rfwr,
  output logic [1:0]  out_tnew,
  output logic        stall
);

  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MDW    = $clog2(MD_MAX + 1);
`ifdef FWD_PATHS_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              d_valid_q, d_valid_d;
  logic [31:0]       d_instr_q, d_instr_d;
  logic [31:0]       d_pc_q, d_pc_d;
  logic [NSTAGE-1:0] sb_v_q, sb_v_d;
  logic [4:0]        sb_a3_q [NSTAGE];
  logic [4:0]        sb_a3_d [NSTAGE];
  logic [1:0]        sb_tnew_q [NSTAGE];
  logic [1:0]        sb_tnew_d [NSTAGE];
  logic [MDW-1:0]    md_cnt_q, md_cnt_d;

  logic [5:0] op_s, fn_s;
  logic [4:0] rs_s, rt_s, rd_s;
  logic       dec_wr_s, dec_md_s, dec_mul_s, dec_div_s;
  logic [4:0] dec_a3_s;
  logic [1:0] dec_tnew_s;
  logic       rs_use_s, rt_use_s;
  logic [1:0] rs_tuse_s, rt_tuse_s;
  logic       rs_haz_s, rt_haz_s, reg_haz_s, md_haz_s;
  logic       stall_s, out_valid_s, issue_s, load_s, rfwr_s;

  assign op_s = d_instr_q[31:26];
  assign rs_s = d_instr_q[25:21];
  assign rt_s = d_instr_q[20:16];
  assign rd_s = d_instr_q[15:11];
  assign fn_s = d_instr_q[5:0];

  // Decode the held instruction: destination, Tnew, operand usage with Tuse, MDU class.
  always_comb begin
    dec_wr_s   = 1'b0;
    dec_a3_s   = 5'd0;
    dec_tnew_s = 2'd0;
    dec_md_s   = 1'b0;
    dec_mul_s  = 1'b0;
    dec_div_s  = 1'b0;
    rs_use_s   = 1'b0;
    rt_use_s   = 1'b0;
    rs_tuse_s  = 2'd1;
    rt_tuse_s  = 2'd1;
    case (op_s)
      6'h00: begin
        case (fn_s)
          6'h00, 6'h02, 6'h03: begin
            dec_wr_s   = 1'b1;
            dec_a3_s   = rd_s;
            dec_tnew_s = 2'd1;
            rt_use_s   = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            dec_wr_s   = 1'b1;
            dec_a3_s   = rd_s;
            dec_tnew_s = 2'd1;
            rs_use_s   = 1'b1;
            rt_use_s   = 1'b1;
          end
          6'h08: begin
            rs_use_s  = 1'b1;
            rs_tuse_s = 2'd0;
          end
          6'h09: begin
            dec_wr_s   = 1'b1;
            dec_a3_s   = rd_s;
            dec_tnew_s = 2'd0;
            rs_use_s   = 1'b1;
            rs_tuse_s  = 2'd0;
          end
          6'h10, 6'h12: begin
            dec_wr_s   = 1'b1;
            dec_a3_s   = rd_s;
            dec_tnew_s = 2'd1;
            dec_md_s   = 1'b1;
          end
          6'h11, 6'h13: begin
            rs_use_s = 1'b1;
            dec_md_s = 1'b1;
          end
          6'h18, 6'h19: begin
            rs_use_s  = 1'b1;
            rt_use_s  = 1'b1;
            dec_md_s  = 1'b1;
            dec_mul_s = 1'b1;
          end
          6'h1a, 6'h1b: begin
            rs_use_s  = 1'b1;
            rt_use_s  = 1'b1;
            dec_md_s  = 1'b1;
            dec_div_s = 1'b1;
          end
          default: dec_wr_s = 1'b0;
        endcase
      end
      6'h01: begin
        if ((rt_s == 5'd0) || (rt_s == 5'd1)) begin
          rs_use_s  = 1'b1;
          rs_tuse_s = 2'd0;
        end else begin
          rs_use_s  = 1'b0;
        end
      end
      6'h03: begin
        dec_wr_s   = 1'b1;
        dec_a3_s   = 5'd31;
        dec_tnew_s = 2'd0;
      end
      6'h04, 6'h05: begin
        rs_use_s  = 1'b1;
        rt_use_s  = 1'b1;
        rs_tuse_s = 2'd0;
        rt_tuse_s = 2'd0;
      end
      6'h06, 6'h07: begin
        rs_use_s  = 1'b1;
        rs_tuse_s = 2'd0;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
        dec_wr_s   = 1'b1;
        dec_a3_s   = rt_s;
        dec_tnew_s = 2'd1;
        rs_use_s   = 1'b1;
      end
      6'h0f: begin
        dec_wr_s   = 1'b1;
        dec_a3_s   = rt_s;
        dec_tnew_s = 2'd1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_wr_s   = 1'b1;
        dec_a3_s   = rt_s;
        dec_tnew_s = 2'd2;
        rs_use_s   = 1'b1;
      end
      6'h28, 6'h29, 6'h2b: begin
        rs_use_s  = 1'b1;
        rt_use_s  = 1'b1;
        rt_tuse_s = 2'd2;
      end
      default: dec_wr_s = 1'b0;
    endcase
  end

  // Scan scoreboard oldest to youngest so the youngest matching writer has the last word.
  always_comb begin
    rs_haz_s = 1'b0;
    rt_haz_s = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (sb_v_q[k] && (sb_a3_q[k] == rs_s)) begin
        rs_haz_s = FWD_EN ? (sb_tnew_q[k] > rs_tuse_s) : (k <= NSTAGE - 2);
      end else begin
        rs_haz_s = rs_haz_s;
      end
      if (sb_v_q[k] && (sb_a3_q[k] == rt_s)) begin
        rt_haz_s = FWD_EN ? (sb_tnew_q[k] > rt_tuse_s) : (k <= NSTAGE - 2);
      end else begin
        rt_haz_s = rt_haz_s;
      end
    end
  end

  assign reg_haz_s   = (rs_use_s && (rs_s != 5'd0) && rs_haz_s) ||
                       (rt_use_s && (rt_s != 5'd0) && rt_haz_s);
  assign md_haz_s    = dec_md_s && (md_cnt_q != '0);
  assign stall_s     = d_valid_q && (reg_haz_s || md_haz_s);
  assign out_valid_s = d_valid_q && !stall_s;
  assign issue_s     = out_valid_s && out_ready;
  assign in_ready    = !d_valid_q || issue_s;
  assign load_s      = in_valid && in_ready;
  assign rfwr_s      = d_valid_q && dec_wr_s && (dec_a3_s != 5'd0);

  assign out_valid = out_valid_s;
  assign stall     = stall_s;
  assign out_instr = d_instr_q;
  assign out_pc    = d_pc_q;
  assign out_rfwr  = rfwr_s;
  assign out_a3    = rfwr_s ? dec_a3_s : 5'd0;
  assign out_tnew  = rfwr_s ? dec_tnew_s : 2'd0;

  // IF/ID register next state; a redirect wins over a same-cycle fetch.
  always_comb begin
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (flush) begin
      d_valid_d = 1'b0;
    end else if (load_s) begin
      d_valid_d = 1'b1;
      d_instr_d = in_instr;
      d_pc_d    = in_pc;
    end else if (issue_s) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end
  end

  // Scoreboard shifts every cycle; Tnew counts down toward zero as the writer advances.
  always_comb begin
    sb_v_d       = '0;
    sb_v_d[0]    = issue_s && rfwr_s;
    sb_a3_d[0]   = issue_s ? out_a3 : 5'd0;
    sb_tnew_d[0] = issue_s ? out_tnew : 2'd0;
    for (int k = 1; k < NSTAGE; k++) begin
      sb_v_d[k]    = sb_v_q[k-1];
      sb_a3_d[k]   = sb_a3_q[k-1];
      sb_tnew_d[k] = (sb_tnew_q[k-1] == 2'd0) ? 2'd0 : (sb_tnew_q[k-1] - 2'd1);
    end
  end

  // MDU busy counter: loaded on mult/div issue, otherwise drains to zero.
  always_comb begin
    if (issue_s && dec_mul_s) begin
      md_cnt_d = MDW'(MUL_LAT);
    end else if (issue_s && dec_div_s) begin
      md_cnt_d = MDW'(DIV_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_valid_q <= 1'b0;
      d_instr_q <= 32'd0;
      d_pc_q    <= 32'd0;
      sb_v_q    <= '0;
      md_cnt_q  <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        sb_a3_q[k]   <= 5'd0;
        sb_tnew_q[k] <= 2'd0;
      end
    end else begin
      d_valid_q <= d_valid_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      sb_v_q    <= sb_v_d;
      md_cnt_q  <= md_cnt_d;
      for (int k = 0; k < NSTAGE; k++) begin
        sb_a3_q[k]   <= sb_a3_d[k];
        sb_tnew_q[k] <= sb_tnew_d[k];
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: decode table, hazard corner sequences,
// and randomized traffic against a timestamp-based issue model.
module tb_decode_issue_stage;
  localparam int NSTAGE  = 3;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef FWD_PATHS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_rfwr, stall;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_a3;
  logic [1:0]  out_tnew;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.NSTAGE(NSTAGE), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_a3(out_a3), .out_rfwr(out_rfwr),
    .out_tnew(out_tnew), .stall(stall)
  );

  typedef struct {int op; int fn; int rtfix; int rs_tu; int rt_tu; int dst; int tnew; int md;} kind_t;
  typedef struct {int cyc; int a3; int tnew;} wr_t;
  typedef struct {logic [31:0] instr; logic [4:0] a3; logic rfwr; logic [1:0] tnew;} vec_t;

  localparam int NK = 20;
  kind_t kinds[NK];
  wr_t   hist[$];
  vec_t  vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] build(input int k, input int rs, input int rt, input int rd, input logic [31:0] rnd);
    int rtf;
    rtf = (kinds[k].rtfix >= 0) ? kinds[k].rtfix : rt;
    if (kinds[k].op == 0) return rtype(rs, rtf, rd, int'(rnd[10:6]), kinds[k].fn);
    return itype(kinds[k].op, rs, rtf, int'(rnd[15:0]));
  endfunction

  // Does the most recent in-window writer of src still block a reader needing it at tuse?
  function automatic bit src_blocks(input int src, input int tuse, input int now);
    int best_age, best_tnew, age;
    best_age  = 0;
    best_tnew = 0;
    if (tuse < 0 || src == 0) return 1'b0;
    foreach (hist[i]) begin
      age = now - hist[i].cyc;
      if (hist[i].a3 == src && age >= 1 && age <= NSTAGE && (best_age == 0 || age < best_age)) begin
        best_age  = age;
        best_tnew = hist[i].tnew;
      end
    end
    if (best_age == 0) return 1'b0;
    if (FWD) return (best_tnew - (best_age - 1)) > tuse;
    return best_age <= NSTAGE - 1;
  endfunction

  task automatic idle(input int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Feed ia then ib back to back; count the cycles ib sits stalled in D.
  task automatic pair(input logic [31:0] ia, input logic [31:0] ib, output int stalls,
                      output logic [4:0] a3a, output logic rfb);
    stalls = 0;
    rfb    = 1'b0;
    idle(DIV_LAT + NSTAGE);
    in_valid = 1'b1; in_instr = ia; in_pc = 32'h0000_0100;
    @(negedge clk);
    in_instr = ib; in_pc = 32'h0000_0104;
    #1;
    a3a = out_a3;
    check("pair_first_issue", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) begin
        rfb = out_rfwr;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, cyc, md_free, k, rs, rt, rd;
    int m_k, m_rs, m_rt, m_rd, e_a3;
    bit m_dv, e_stall, e_ov, e_issue, e_ir;
    logic [31:0] m_instr, m_pc, ins;
    logic [4:0] a3a;
    logic rfb;

    kinds[0]  = '{0, 'h21, -1,  1,  1, 1, 1, 0};  // addu
    kinds[1]  = '{0, 'h04, -1,  1,  1, 1, 1, 0};  // sllv
    kinds[2]  = '{0, 'h00, -1, -1,  1, 1, 1, 0};  // sll
    kinds[3]  = '{0, 'h12, -1, -1, -1, 1, 1, 1};  // mflo
    kinds[4]  = '{0, 'h11, -1,  1, -1, 0, 0, 1};  // mthi
    kinds[5]  = '{0, 'h18, -1,  1,  1, 0, 0, 2};  // mult
    kinds[6]  = '{0, 'h1b, -1,  1,  1, 0, 0, 3};  // divu
    kinds[7]  = '{0, 'h08, -1,  0, -1, 0, 0, 0};  // jr
    kinds[8]  = '{0, 'h09, -1,  0, -1, 1, 0, 0};  // jalr
    kinds[9]  = '{'h0d, 0, -1,  1, -1, 2, 1, 0};  // ori
    kinds[10] = '{'h0f, 0, -1, -1, -1, 2, 1, 0};  // lui
    kinds[11] = '{'h23, 0, -1,  1, -1, 2, 2, 0};  // lw
    kinds[12] = '{'h2b, 0, -1,  1,  2, 0, 0, 0};  // sw
    kinds[13] = '{'h04, 0, -1,  0,  0, 0, 0, 0};  // beq
    kinds[14] = '{'h07, 0, -1,  0, -1, 0, 0, 0};  // bgtz
    kinds[15] = '{'h01, 0,  1,  0, -1, 0, 0, 0};  // bgez
    kinds[16] = '{'h03, 0, -1, -1, -1, 3, 0, 0};  // jal
    kinds[17] = '{0, 'h2a, -1,  1,  1, 1, 1, 0};  // slt
    kinds[18] = '{'h02, 0, -1, -1, -1, 0, 0, 0};  // j
    kinds[19] = '{'h20, 0, -1,  1, -1, 2, 2, 0};  // lb

    vecs[0]  = '{rtype(1, 2, 3, 0, 'h21),  5'd3,  1'b1, 2'd1};  // addu $3,$1,$2
    vecs[1]  = '{itype('h23, 1, 2, 4),     5'd2,  1'b1, 2'd2};  // lw $2,4($1)
    vecs[2]  = '{itype('h03, 5, 6, 'h40),  5'd31, 1'b1, 2'd0};  // jal
    vecs[3]  = '{rtype(1, 0, 3, 0, 'h09),  5'd3,  1'b1, 2'd0};  // jalr $3,$1
    vecs[4]  = '{itype('h2b, 1, 2, 8),     5'd0,  1'b0, 2'd0};  // sw
    vecs[5]  = '{itype('h0f, 0, 2, 'h1234),5'd2,  1'b1, 2'd1};  // lui $2
    vecs[6]  = '{32'h0000_0000,            5'd0,  1'b0, 2'd0};  // nop
    vecs[7]  = '{itype('h0d, 1, 0, 5),     5'd0,  1'b0, 2'd0};  // ori $0 -> no write
    vecs[8]  = '{rtype(0, 0, 3, 0, 'h10),  5'd3,  1'b1, 2'd1};  // mfhi $3
    vecs[9]  = '{itype('h04, 1, 2, 3),     5'd0,  1'b0, 2'd0};  // beq
    vecs[10] = '{rtype(0, 2, 3, 4, 'h00),  5'd3,  1'b1, 2'd1};  // sll $3,$2,4
    vecs[11] = '{itype('h09, 4, 7, 1),     5'd7,  1'b1, 2'd1};  // addiu $7

    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall",     32'(stall),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_a3",    32'(out_a3),    32'd0);
    check("rst_out_rfwr",  32'(out_rfwr),  32'd0);
    check("rst_out_tnew",  32'(out_tnew),  32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      idle(DIV_LAT + NSTAGE);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
      check($sformatf("vec%0d_a3", i),    32'(out_a3),   32'(vecs[i].a3));
      check($sformatf("vec%0d_rfwr", i),  32'(out_rfwr), 32'(vecs[i].rfwr));
      check($sformatf("vec%0d_tnew", i),  32'(out_tnew), 32'(vecs[i].tnew));
      @(negedge clk);
    end

    pair(itype('h23, 0, 8, 0), rtype(8, 8, 9, 0, 'h21), st, a3a, rfb);
    check("lw_addu_stalls", 32'(st), FWD ? 32'd1 : 32'(NSTAGE - 1));
    pair(itype('h23, 0, 8, 0), itype('h04, 8, 0, 0), st, a3a, rfb);
    check("lw_beq_stalls", 32'(st), 32'd2);
    pair(itype('h0d, 0, 8, 5), itype('h2b, 0, 8, 0), st, a3a, rfb);
    check("ori_sw_stalls", 32'(st), FWD ? 32'd0 : 32'(NSTAGE - 1));
    check("ori_a3", 32'(a3a), 32'd8);
    check("sw_rfwr", 32'(rfb), 32'd0);
    pair(rtype(1, 2, 0, 0, 'h18), rtype(0, 0, 3, 0, 'h12), st, a3a, rfb);
    check("mult_mflo_stalls", 32'(st), 32'(MUL_LAT));
    pair(rtype(1, 2, 0, 0, 'h1a), rtype(0, 0, 3, 0, 'h10), st, a3a, rfb);
    check("div_mfhi_stalls", 32'(st), 32'(DIV_LAT));

    // lw issues in the same cycle that a flush kills the incoming fetch.
    idle(DIV_LAT + NSTAGE);
    in_valid = 1'b1; in_instr = itype('h23, 0, 8, 0);
    @(negedge clk);
    flush = 1'b1; in_instr = itype('h0d, 0, 9, 1);
    #1;
    check("flush_lw_issue", 32'(out_valid), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_instr = itype('h04, 8, 0, 0);
    #1;
    check("flush_d_empty", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    st = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) break;
      st++;
      @(negedge clk);
    end
    check("flush_beq_stalls", 32'(st), 32'd1);
    @(negedge clk);

    // Reset mid-stream with D occupied and the MDU busy.
    idle(DIV_LAT + NSTAGE);
    in_valid = 1'b1; in_instr = rtype(1, 2, 0, 0, 'h18);
    @(negedge clk);
    in_instr = rtype(1, 2, 3, 0, 'h21);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("mid_d_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall",     32'(stall),     32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    reset_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = rtype(0, 0, 3, 0, 'h12);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mid_rst_md_clear", 32'(out_valid), 32'd1);
    @(negedge clk);

    // Randomized traffic against the issue model.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
    cyc = 0; md_free = 0; m_dv = 1'b0;
    m_k = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_instr = 32'd0; m_pc = 32'd0;
    for (int n = 0; n < 2500; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      k  = $urandom_range(NK - 1);
      rs = $urandom_range(3); rt = $urandom_range(3); rd = $urandom_range(3);
      ins = build(k, rs, rt, rd, $urandom);
      in_instr = ins; in_pc = $urandom;
      #1;
      e_stall = m_dv && ((kinds[m_k].md != 0 && cyc < md_free) ||
                         src_blocks(m_rs, kinds[m_k].rs_tu, cyc) ||
                         src_blocks(m_rt, kinds[m_k].rt_tu, cyc));
      e_ov    = m_dv && !e_stall;
      e_issue = e_ov && out_ready;
      e_ir    = !m_dv || e_issue;
      case (kinds[m_k].dst)
        1: e_a3 = m_rd;
        2: e_a3 = m_rt;
        3: e_a3 = 31;
        default: e_a3 = 0;
      endcase
      check("rnd_stall",     32'(stall),     32'(e_stall));
      check("rnd_out_valid", 32'(out_valid), 32'(e_ov));
      check("rnd_in_ready",  32'(in_ready),  32'(e_ir));
      if (e_ov) begin
        check("rnd_instr", out_instr, m_instr);
        check("rnd_pc",    out_pc,    m_pc);
        check("rnd_a3",    32'(out_a3),   32'(e_a3));
        check("rnd_rfwr",  32'(out_rfwr), 32'(e_a3 != 0));
        check("rnd_tnew",  32'(out_tnew), (e_a3 != 0) ? 32'(kinds[m_k].tnew) : 32'd0);
      end
      if (e_issue) begin
        if (e_a3 != 0) hist.push_back('{cyc, e_a3, kinds[m_k].tnew});
        if (kinds[m_k].md == 2) md_free = cyc + 1 + MUL_LAT;
        if (kinds[m_k].md == 3) md_free = cyc + 1 + DIV_LAT;
      end
      if (flush) begin
        m_dv = 1'b0;
      end else if (in_valid && e_ir) begin
        m_dv = 1'b1; m_k = k; m_instr = ins; m_pc = in_pc;
        m_rs = int'(ins[25:21]); m_rt = int'(ins[20:16]); m_rd = int'(ins[15:11]);
      end else if (e_issue) begin
        m_dv = 1'b0;
      end
      cyc++;
      while (hist.size() > 0 && (cyc - hist[0].cyc) > NSTAGE) void'(hist.pop_front());
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
